// File: rtl/answer_entry_n_if.sv
// Answer-entry bus: game state, question bus, buttons and judge handshake
// on one side, display nibbles and committed answer on the other.
interface answer_entry_n_if #(
  parameter int N_CH     = 3,
  parameter int DIGIT_W  = 4,
  parameter int Q_DIGITS = 3,
  parameter int QB_W     = 24
);
  logic [3:0]                  STATE;
  logic [QB_W-1:0]             QUESTION;
  logic [N_CH-1:0]             SEL;
  logic                        DIR;
  logic                        CLR;
  logic                        DEC;
  logic                        OUT_ACK;
  logic [N_CH*DIGIT_W-1:0]     SEG;
  logic [Q_DIGITS*DIGIT_W-1:0] SEG_Q;
  logic [N_CH*DIGIT_W-1:0]     COUNT_OUT;
  logic                        OUT_VALID;
  logic                        QUE_OK;
  logic                        LED;

  // Driver side: synchroniser/state machine/judge.
  modport master (
    output STATE, QUESTION, SEL, DIR, CLR, DEC, OUT_ACK,
    input  SEG, SEG_Q, COUNT_OUT, OUT_VALID, QUE_OK, LED
  );

  // Answer-entry block side.
  modport slave (
    input  STATE, QUESTION, SEL, DIR, CLR, DEC, OUT_ACK,
    output SEG, SEG_Q, COUNT_OUT, OUT_VALID, QUE_OK, LED
  );
endinterface

// File: rtl/answer_entry_n.sv
// Answer-entry front end for the factorisation game: per-channel digit
// counters stepped by edge-detected buttons, question latch, display
// registers and a valid/ack handoff of the committed answer to the judge.
module answer_entry_n #(
  parameter int N_CH     = 3,
  parameter int DIGIT_W  = 4,
  parameter int MAX_VAL  = 9,
  parameter int MIN_VAL  = 1,
  parameter int Q_DIGITS = 3,
  parameter int QB_W     = 24,
  parameter int Q_LSB    = 12
) (
  input  logic CLK,
  input  logic RST,
  answer_entry_n_if.slave bus
);

  localparam int QW = Q_DIGITS * DIGIT_W;

  localparam logic [3:0] ST_QUESTION = 4'd3;
  localparam logic [3:0] ST_INPUT    = 4'd4;

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_VAL);
  localparam logic [DIGIT_W-1:0] MIN_D = DIGIT_W'(MIN_VAL);

  logic [N_CH-1:0][DIGIT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]              sel_q, sel_d;
  logic                         dec_q, dec_d;
  logic [QW-1:0]                q_r_q, q_r_d;
  logic [N_CH*DIGIT_W-1:0]      seg_ans_q, seg_ans_d;
  logic [QW-1:0]                seg_que_q, seg_que_d;
  logic [N_CH*DIGIT_W-1:0]      count_out_q, count_out_d;
  logic                         out_valid_q, out_valid_d;
  logic                         que_ok_q, que_ok_d;
  logic                         led_q, led_d;

  logic [N_CH-1:0] press;
  logic            dec_edge;
  logic            clear_st;
  logic            in_input;
  logic            found;

  // Only the question field is latched; the rest of the bus is deliberately ignored.
  logic unused_question;
  assign unused_question = ^bus.QUESTION;

  // Wrapping single step of one digit; anything at or below MIN_VAL (including
  // the cleared 0) wraps to MAX_VAL when stepping down.
  function automatic logic [DIGIT_W-1:0] step_digit(input logic [DIGIT_W-1:0] v,
                                                     input logic down);
    if (down) return (v <= MIN_D) ? MAX_D : v - 1'b1;
    else      return (v == MAX_D) ? MIN_D : v + 1'b1;
  endfunction

  // Button edges and state decode.
  always_comb begin
    press    = bus.SEL & ~sel_q;
    dec_edge = bus.DEC & ~dec_q;
    clear_st = bus.STATE inside {4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
    in_input = (bus.STATE == ST_INPUT);
    sel_d    = bus.SEL;
    dec_d    = bus.DEC;
  end

  // Counter update: lowest pressed channel wins, any press beats CLR.
  always_comb begin
    cnt_d = cnt_q;
    found = 1'b0;
    if (clear_st) begin
      cnt_d = '0;
    end else if (in_input) begin
      for (int i = 0; i < N_CH; i++) begin
        if (press[i] && !found) begin
          found    = 1'b1;
          cnt_d[i] = step_digit(cnt_q[i], bus.DIR);
        end
      end
      if (!found && bus.CLR) cnt_d = '0;
    end
  end

  // Question latch and its delayed non-zero flags.
  always_comb begin
    q_r_d    = clear_st ? '0 : bus.QUESTION[Q_LSB +: QW];
    que_ok_d = (q_r_q != '0);
    led_d    = que_ok_q;
  end

  // Display registers, blanked outside their owning state.
  always_comb begin
    seg_ans_d = in_input ? cnt_q : '0;
    seg_que_d = (bus.STATE == ST_QUESTION) ? q_r_q : '0;
  end

  // Decide handshake: ACK retires the answer before a new decide is considered,
  // so a decide arriving in the same cycle as ACK is dropped.
  always_comb begin
    count_out_d = count_out_q;
    out_valid_d = out_valid_q;
    if (clear_st) begin
      count_out_d = '0;
      out_valid_d = 1'b0;
    end else if (out_valid_q) begin
      if (bus.OUT_ACK) out_valid_d = 1'b0;
    end else if (dec_edge && in_input) begin
      count_out_d = cnt_q;
      out_valid_d = 1'b1;
    end
  end

  // All state registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q       <= '0;
      sel_q       <= '0;
      dec_q       <= 1'b0;
      q_r_q       <= '0;
      seg_ans_q   <= '0;
      seg_que_q   <= '0;
      count_out_q <= '0;
      out_valid_q <= 1'b0;
      que_ok_q    <= 1'b0;
      led_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      dec_q       <= dec_d;
      q_r_q       <= q_r_d;
      seg_ans_q   <= seg_ans_d;
      seg_que_q   <= seg_que_d;
      count_out_q <= count_out_d;
      out_valid_q <= out_valid_d;
      que_ok_q    <= que_ok_d;
      led_q       <= led_d;
    end
  end

  assign bus.SEG       = seg_ans_q;
  assign bus.SEG_Q     = seg_que_q;
  assign bus.COUNT_OUT = count_out_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.QUE_OK    = que_ok_q;
  assign bus.LED       = led_q;

endmodule

// File: tb/tb_answer_entry_n.sv
// Bench for answer_entry_n: directed scenarios against hand-derived values,
// then randomized traffic against a behavioural model of the game rules.
module tb_answer_entry_n;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  answer_entry_n_if #(.N_CH(3), .DIGIT_W(4), .Q_DIGITS(3), .QB_W(24)) bus ();

  answer_entry_n #(
    .N_CH(3), .DIGIT_W(4), .MAX_VAL(9), .MIN_VAL(1),
    .Q_DIGITS(3), .QB_W(24), .Q_LSB(12)
  ) dut (
    .CLK(clk),
    .RST(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  int          m_cnt[3];
  bit   [2:0]  m_sel_q;
  bit          m_dec_q;
  logic [11:0] m_q, m_seg, m_segq, m_cout;
  bit          m_valid, m_qok, m_led;

  function automatic logic [11:0] pack3(input int c[3]);
    logic [11:0] v;
    v = '0;
    for (int i = 0; i < 3; i++) v = v | (12'(c[i]) << (4 * i));
    return v;
  endfunction

  // Advance one clock, evolving the model from the inputs presented this cycle.
  task automatic tick();
    int          n_cnt[3];
    logic [11:0] n_q, n_seg, n_segq, n_cout;
    bit          n_valid, n_qok, n_led;
    bit   [2:0]  press;
    bit          dedge, clr_st, in_st;
    int          st;
    st      = int'(bus.STATE);
    n_cnt   = m_cnt;
    n_cout  = m_cout;
    n_valid = m_valid;
    press   = bus.SEL & ~m_sel_q;
    dedge   = bus.DEC & ~m_dec_q;
    clr_st  = (st == 6) || (st == 8) || (st == 9) || (st == 10) || (st == 11);
    in_st   = (st == 4);
    n_seg   = in_st ? pack3(m_cnt) : 12'h000;
    n_segq  = (st == 3) ? m_q : 12'h000;
    n_q     = clr_st ? 12'h000 : 12'(bus.QUESTION >> 12);
    n_qok   = (m_q != 0);
    n_led   = m_qok;
    if (clr_st) begin
      for (int i = 0; i < 3; i++) n_cnt[i] = 0;
      n_valid = 0;
      n_cout  = 12'h000;
    end else begin
      if (in_st) begin
        if (press != 0) begin
          for (int i = 0; i < 3; i++) begin
            if (press[i]) begin
              if (bus.DIR) n_cnt[i] = (m_cnt[i] <= 1) ? 9 : m_cnt[i] - 1;
              else         n_cnt[i] = (m_cnt[i] % 9) + 1;
              break;
            end
          end
        end else if (bus.CLR) begin
          for (int i = 0; i < 3; i++) n_cnt[i] = 0;
        end
      end
      if (m_valid && bus.OUT_ACK) n_valid = 0;
      else if (!m_valid && dedge && in_st) begin
        n_valid = 1;
        n_cout  = pack3(m_cnt);
      end
    end
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) n_cnt[i] = 0;
      n_q = 0; n_seg = 0; n_segq = 0; n_cout = 0;
      n_valid = 0; n_qok = 0; n_led = 0;
      press = 0; dedge = 0;
    end
    @(posedge clk);
    #1;
    m_cnt   = n_cnt;
    m_sel_q = rst_n ? bus.SEL : 3'b000;
    m_dec_q = rst_n ? bus.DEC : 1'b0;
    m_q     = n_q;
    m_seg   = n_seg;
    m_segq  = n_segq;
    m_cout  = n_cout;
    m_valid = n_valid;
    m_qok   = n_qok;
    m_led   = n_led;
  endtask

  task automatic press_ch(input int ch);
    bus.SEL = 3'(1 << ch);
    tick();
    bus.SEL = 3'b000;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.SEG !== 12'h000 || bus.SEG_Q !== 12'h000) begin
      n_bad++; $display("FAIL reset_seg got SEG=%h SEG_Q=%h exp 000/000", bus.SEG, bus.SEG_Q);
    end
    n_cmp++;
    if (bus.COUNT_OUT !== 12'h000 || bus.OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL reset_out got COUNT_OUT=%h OUT_VALID=%b exp 000/0", bus.COUNT_OUT, bus.OUT_VALID);
    end
    n_cmp++;
    if (bus.QUE_OK !== 1'b0 || bus.LED !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got QUE_OK=%b LED=%b exp 0/0", bus.QUE_OK, bus.LED);
    end
  endtask

  task automatic test_single_step();
    rst_n     = 1'b1;
    bus.STATE = 4'd4;
    bus.SEL   = 3'b001;
    tick();
    tick();
    n_cmp++;
    if (bus.SEG !== 12'h001) begin
      n_bad++; $display("FAIL single_step got SEG=%h exp 001", bus.SEG);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (bus.SEG !== 12'h001) begin
      n_bad++; $display("FAIL held_button got SEG=%h exp 001", bus.SEG);
    end
    bus.SEL = 3'b000;
    tick();
  endtask

  task automatic test_wrap();
    bus.DIR = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      press_ch(1);
      n_cmp++;
      if (bus.SEG[7:4] !== 4'(((k - 1) % 9) + 1)) begin
        n_bad++; $display("FAIL wrap_up_%0d got %0d exp %0d", k, bus.SEG[7:4], ((k - 1) % 9) + 1);
      end
    end
    bus.DIR = 1'b1;
    press_ch(1);
    n_cmp++;
    if (bus.SEG[7:4] !== 4'd9) begin
      n_bad++; $display("FAIL wrap_down_from1 got %0d exp 9", bus.SEG[7:4]);
    end
    bus.CLR = 1'b1; tick();
    bus.CLR = 1'b0; tick();
    n_cmp++;
    if (bus.SEG !== 12'h000) begin
      n_bad++; $display("FAIL clr got SEG=%h exp 000", bus.SEG);
    end
    press_ch(1);
    n_cmp++;
    if (bus.SEG !== 12'h090) begin
      n_bad++; $display("FAIL down_from0 got SEG=%h exp 090", bus.SEG);
    end
    bus.DIR = 1'b0;
  endtask

  task automatic test_priority();
    bus.SEL = 3'b011;
    bus.CLR = 1'b1;
    tick();
    bus.SEL = 3'b000;
    bus.CLR = 1'b0;
    tick();
    n_cmp++;
    if (bus.SEG !== 12'h091) begin
      n_bad++; $display("FAIL priority got SEG=%h exp 091", bus.SEG);
    end
  endtask

  task automatic test_decide();
    bus.CLR = 1'b1; tick();
    bus.CLR = 1'b0; tick();
    for (int k = 0; k < 3; k++) press_ch(0);
    for (int k = 0; k < 5; k++) press_ch(1);
    for (int k = 0; k < 7; k++) press_ch(2);
    bus.DEC = 1'b1; tick();
    n_cmp++;
    if (bus.COUNT_OUT !== 12'h753 || bus.OUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL decide got COUNT_OUT=%h OUT_VALID=%b exp 753/1", bus.COUNT_OUT, bus.OUT_VALID);
    end
    bus.DEC = 1'b0; tick();
    press_ch(0);
    bus.DEC = 1'b1; tick();
    bus.DEC = 1'b0; tick();
    n_cmp++;
    if (bus.COUNT_OUT !== 12'h753 || bus.OUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL second_dec got COUNT_OUT=%h OUT_VALID=%b exp 753/1", bus.COUNT_OUT, bus.OUT_VALID);
    end
    bus.OUT_ACK = 1'b1; tick();
    n_cmp++;
    if (bus.OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL ack got OUT_VALID=%b exp 0", bus.OUT_VALID);
    end
    tick();
    n_cmp++;
    if (bus.OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL ack_idle got OUT_VALID=%b exp 0", bus.OUT_VALID);
    end
    bus.OUT_ACK = 1'b0;
    bus.DEC = 1'b1; tick();
    n_cmp++;
    if (bus.COUNT_OUT !== 12'h754 || bus.OUT_VALID !== 1'b1) begin
      n_bad++; $display("FAIL redecide got COUNT_OUT=%h OUT_VALID=%b exp 754/1", bus.COUNT_OUT, bus.OUT_VALID);
    end
    bus.DEC = 1'b0; tick();
    bus.DEC = 1'b1; bus.OUT_ACK = 1'b1; tick();
    bus.DEC = 1'b0; bus.OUT_ACK = 1'b0; tick();
    n_cmp++;
    if (bus.OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL ack_beats_dec got OUT_VALID=%b exp 0", bus.OUT_VALID);
    end
  endtask

  task automatic test_question();
    bus.DEC = 1'b1; tick();
    bus.DEC = 1'b0; tick();
    bus.STATE    = 4'd3;
    bus.QUESTION = 24'h00A000;
    tick();
    tick();
    n_cmp++;
    if (bus.SEG_Q !== 12'h00A || bus.QUE_OK !== 1'b1 || bus.LED !== 1'b0 || bus.SEG !== 12'h000) begin
      n_bad++; $display("FAIL question got SEG_Q=%h QUE_OK=%b LED=%b SEG=%h exp 00A/1/0/000",
                        bus.SEG_Q, bus.QUE_OK, bus.LED, bus.SEG);
    end
    tick();
    n_cmp++;
    if (bus.LED !== 1'b1) begin
      n_bad++; $display("FAIL led_delay got LED=%b exp 1", bus.LED);
    end
    bus.STATE = 4'd9;
    tick();
    n_cmp++;
    if (bus.OUT_VALID !== 1'b0 || bus.COUNT_OUT !== 12'h000) begin
      n_bad++; $display("FAIL clear_state_out got OUT_VALID=%b COUNT_OUT=%h exp 0/000", bus.OUT_VALID, bus.COUNT_OUT);
    end
    tick();
    n_cmp++;
    if (bus.QUE_OK !== 1'b0) begin
      n_bad++; $display("FAIL clear_state_qok got QUE_OK=%b exp 0", bus.QUE_OK);
    end
    bus.STATE = 4'd4;
    tick();
    n_cmp++;
    if (bus.SEG !== 12'h000) begin
      n_bad++; $display("FAIL clear_state_cnt got SEG=%h exp 000", bus.SEG);
    end
  endtask

  task automatic test_reset_mid();
    press_ch(2);
    bus.DEC = 1'b1; tick();
    bus.DEC = 1'b0;
    bus.SEL = 3'b001;
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (bus.SEG !== 12'h000 || bus.SEG_Q !== 12'h000 || bus.COUNT_OUT !== 12'h000 ||
        bus.OUT_VALID !== 1'b0 || bus.QUE_OK !== 1'b0 || bus.LED !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid got SEG=%h SEG_Q=%h CO=%h V=%b Q=%b L=%b exp all 0",
                        bus.SEG, bus.SEG_Q, bus.COUNT_OUT, bus.OUT_VALID, bus.QUE_OK, bus.LED);
    end
    bus.SEL = 3'b000;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.SEG !== 12'h000 || bus.OUT_VALID !== 1'b0) begin
      n_bad++; $display("FAIL after_reset got SEG=%h OUT_VALID=%b exp 000/0", bus.SEG, bus.OUT_VALID);
    end
    press_ch(0);
    n_cmp++;
    if (bus.SEG !== 12'h001) begin
      n_bad++; $display("FAIL fresh_press got SEG=%h exp 001", bus.SEG);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5)      bus.STATE = 4'd4;
      else if (r == 6) bus.STATE = 4'd3;
      else if (r == 7) bus.STATE = 4'd9;
      else if (r == 8) bus.STATE = 4'd6;
      else             bus.STATE = 4'($urandom_range(0, 15));
      rst_n       = ($urandom_range(0, 63) != 0);
      bus.SEL     = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
      bus.DIR     = 1'($urandom_range(0, 1));
      bus.CLR     = ($urandom_range(0, 7) == 0);
      bus.DEC     = ($urandom_range(0, 2) == 0);
      bus.OUT_ACK = ($urandom_range(0, 3) == 0);
      bus.QUESTION = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 4095)) : 24'($urandom);
      tick();
      n_cmp++;
      if (bus.SEG !== m_seg) begin
        n_bad++; $display("FAIL rnd_seg cyc %0d got %h exp %h", c, bus.SEG, m_seg);
      end
      n_cmp++;
      if (bus.SEG_Q !== m_segq) begin
        n_bad++; $display("FAIL rnd_seg_q cyc %0d got %h exp %h", c, bus.SEG_Q, m_segq);
      end
      n_cmp++;
      if (bus.COUNT_OUT !== m_cout) begin
        n_bad++; $display("FAIL rnd_count_out cyc %0d got %h exp %h", c, bus.COUNT_OUT, m_cout);
      end
      n_cmp++;
      if (bus.OUT_VALID !== m_valid) begin
        n_bad++; $display("FAIL rnd_out_valid cyc %0d got %b exp %b", c, bus.OUT_VALID, m_valid);
      end
      n_cmp++;
      if (bus.QUE_OK !== m_qok) begin
        n_bad++; $display("FAIL rnd_que_ok cyc %0d got %b exp %b", c, bus.QUE_OK, m_qok);
      end
      n_cmp++;
      if (bus.LED !== m_led) begin
        n_bad++; $display("FAIL rnd_led cyc %0d got %b exp %b", c, bus.LED, m_led);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_sel_q = 0; m_dec_q = 0;
    m_q = 0; m_seg = 0; m_segq = 0; m_cout = 0;
    m_valid = 0; m_qok = 0; m_led = 0;
    rst_n        = 1'b0;
    bus.STATE    = 4'd0;
    bus.QUESTION = 24'h0;
    bus.SEL      = 3'b000;
    bus.DIR      = 1'b0;
    bus.CLR      = 1'b0;
    bus.DEC      = 1'b0;
    bus.OUT_ACK  = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_step();
    test_wrap();
    test_priority();
    test_decide();
    test_question();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
